// File: rtl/cpu_muldiv_unit_pkg.sv
// Shared types for the iterative multiply/divide unit.
//   muldiv_op_t    : RISC-V M-extension funct3 encodings
//   muldiv_state_t : unit FSM states
//   helpers        : operand signedness and mul/div class from funct3
package cpu_muldiv_unit_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    function automatic logic op1_is_signed(input muldiv_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op2_is_signed(input muldiv_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_is_div(input muldiv_op_t op);
        return op[2];
    endfunction

endpackage

// File: rtl/cpu_muldiv_unit_step.sv
// One combinational iteration of the shift-add multiplier / restoring divider.
//   is_div           : 1 = divide step, 0 = multiply step
//   acc_in, acc_out  : product high half / partial remainder
//   q_in, q_out      : multiplier being shifted out (low product half) / dividend->quotient
//   b                : multiplicand / divisor magnitude
module cpu_muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] acc_in,
    input  logic [XLEN-1:0] q_in,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] acc_out,
    output logic [XLEN-1:0] q_out
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;

    always_comb begin
        sum     = {1'b0, acc_in} + (q_in[0] ? {1'b0, b} : '0);
        shifted = {acc_in, q_in[XLEN-1]};
        if (is_div) begin
            // When the subtraction succeeds the difference is below b, so XLEN bits suffice.
            if (shifted >= {1'b0, b}) begin
                acc_out = shifted[XLEN-1:0] - b;
                q_out   = {q_in[XLEN-2:0], 1'b1};
            end else begin
                acc_out = shifted[XLEN-1:0];
                q_out   = {q_in[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_out = sum[XLEN:1];
            q_out   = {sum[0], q_in[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/cpu_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit with request/result handshakes.
//   i_clock, i_reset          : clock, synchronous active-high reset
//   i_valid/o_ready           : request handshake (i_op funct3, i_tag, i_op1, i_op2)
//   i_flush                   : abort in-flight op or drop pending result
//   o_valid/i_result_ready    : result handshake (o_result, o_tag)
//   o_busy                    : op in flight, execute must stall
module cpu_muldiv_unit #(
    parameter int XLEN      = 32,
    parameter int STEPS     = 1,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [2:0]           i_op,
    input  logic [TAG_WIDTH-1:0] i_tag,
    input  logic [XLEN-1:0]      i_op1,
    input  logic [XLEN-1:0]      i_op2,
    input  logic                 i_flush,
    output logic                 o_valid,
    input  logic                 i_result_ready,
    output logic [XLEN-1:0]      o_result,
    output logic [TAG_WIDTH-1:0] o_tag,
    output logic                 o_busy
);

    import cpu_muldiv_unit_pkg::*;

    localparam int N  = XLEN / STEPS;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0]   LAST = CW'(N);
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t      state;
    logic [CW-1:0]      cnt;
    logic [XLEN-1:0]    acc, q, b;
    muldiv_op_t         op_r;
    logic [TAG_WIDTH-1:0] tag_r;
    logic               neg1_r, neg2_r;

    // Accept-time operand preparation and special-case detection
    muldiv_op_t      op_in;
    logic            neg1_in, neg2_in, div_zero, div_ovf;
    logic [XLEN-1:0] abs1_in, abs2_in, special_result;

    always_comb begin
        op_in    = muldiv_op_t'(i_op);
        neg1_in  = op1_is_signed(op_in) && i_op1[XLEN-1];
        neg2_in  = op2_is_signed(op_in) && i_op2[XLEN-1];
        abs1_in  = neg1_in ? -i_op1 : i_op1;
        abs2_in  = neg2_in ? -i_op2 : i_op2;
        div_zero = op_is_div(op_in) && (i_op2 == '0);
        div_ovf  = (op_in == OP_DIV || op_in == OP_REM) && (i_op1 == XMIN) && (i_op2 == '1);
        special_result = '0;
        if (div_zero)
            special_result = (op_in == OP_DIV || op_in == OP_DIVU) ? '1 : i_op1;
        else if (div_ovf)
            special_result = (op_in == OP_DIV) ? i_op1 : '0;
    end

    // STEPS chained iterations per RUN cycle
    logic [XLEN-1:0] acc_c [0:STEPS];
    logic [XLEN-1:0] q_c   [0:STEPS];

    assign acc_c[0] = acc;
    assign q_c[0]   = q;

    for (genvar g = 0; g < STEPS; g++) begin : g_step
        cpu_muldiv_step #(.XLEN(XLEN)) u_step (
            .is_div  (op_is_div(op_r)),
            .acc_in  (acc_c[g]),
            .q_in    (q_c[g]),
            .b       (b),
            .acc_out (acc_c[g+1]),
            .q_out   (q_c[g+1])
        );
    end

    // Sign fix-up and result select
    logic [2*XLEN-1:0] product_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

    always_comb begin
        product_fix = (neg1_r ^ neg2_r) ? -{acc, q} : {acc, q};
        quo_fix     = (neg1_r ^ neg2_r) ? -q : q;
        rem_fix     = neg1_r ? -acc : acc;
        case (op_r)
            OP_MUL:                       fix_result = product_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = product_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_result = quo_fix;
            default:                      fix_result = rem_fix;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            q        <= '0;
            b        <= '0;
            op_r     <= OP_MUL;
            tag_r    <= '0;
            neg1_r   <= 1'b0;
            neg2_r   <= 1'b0;
            o_valid  <= 1'b0;
            o_result <= '0;
            o_tag    <= '0;
        end else if (i_flush) begin
            state   <= IDLE;
            o_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_valid) begin
                    op_r   <= op_in;
                    tag_r  <= i_tag;
                    neg1_r <= neg1_in;
                    neg2_r <= neg2_in;
                    acc    <= '0;
                    q      <= abs1_in;
                    b      <= abs2_in;
                    cnt    <= '0;
                    if (div_zero || div_ovf) begin
                        o_result <= special_result;
                        o_tag    <= i_tag;
                        o_valid  <= 1'b1;
                        state    <= DONE;
                    end else begin
                        state <= RUN;
                    end
                end
                // Terminal count is seen one cycle after the last iteration; that cycle only exits.
                RUN: if (cnt == LAST) begin
                    state <= FIX;
                end else begin
                    acc <= acc_c[STEPS];
                    q   <= q_c[STEPS];
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    o_result <= fix_result;
                    o_tag    <= tag_r;
                    o_valid  <= 1'b1;
                    state    <= DONE;
                end
                DONE: if (i_result_ready) begin
                    o_valid <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_ready = (state == IDLE);
    assign o_busy  = (state != IDLE);

endmodule

// File: tb/tb_cpu_muldiv_unit.sv
// Directed bench for cpu_muldiv_unit: one instance at XLEN=32/STEPS=1 and one at
// XLEN=64/STEPS=4 share the stimulus; sel chooses which one is driven and observed.
module tb_cpu_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst, valid, flush, rr, sel;
    logic [2:0]  op;
    logic [3:0]  tag;
    logic [63:0] op1, op2;

    logic        rdy32, v32, busy32, rdy64, v64, busy64;
    logic [31:0] res32;
    logic [63:0] res64;
    logic [3:0]  tag32, tag64;

    logic        obs_ready, obs_valid, obs_busy;
    logic [63:0] obs_result;
    logic [3:0]  obs_tag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_muldiv_unit #(.XLEN(32), .STEPS(1), .TAG_WIDTH(4)) dut32 (
        .i_clock(clk), .i_reset(rst), .i_valid(valid && !sel), .o_ready(rdy32),
        .i_op(op), .i_tag(tag), .i_op1(op1[31:0]), .i_op2(op2[31:0]), .i_flush(flush),
        .o_valid(v32), .i_result_ready(rr), .o_result(res32), .o_tag(tag32), .o_busy(busy32)
    );

    cpu_muldiv_unit #(.XLEN(64), .STEPS(4), .TAG_WIDTH(4)) dut64 (
        .i_clock(clk), .i_reset(rst), .i_valid(valid && sel), .o_ready(rdy64),
        .i_op(op), .i_tag(tag), .i_op1(op1), .i_op2(op2), .i_flush(flush),
        .o_valid(v64), .i_result_ready(rr), .o_result(res64), .o_tag(tag64), .o_busy(busy64)
    );

    always_comb begin
        if (sel) begin
            obs_ready = rdy64; obs_valid = v64; obs_busy = busy64;
            obs_result = res64; obs_tag = tag64;
        end else begin
            obs_ready = rdy32; obs_valid = v32; obs_busy = busy32;
            obs_result = {32'h0, res32}; obs_tag = tag32;
        end
    end

    function automatic logic [63:0] mask();
        return sel ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    endfunction

    function automatic int lat_norm();
        return sel ? 18 : 34;
    endfunction

    task automatic issue(input logic [2:0] o, input logic [63:0] a, input logic [63:0] bb,
                         input logic [3:0] t);
        @(negedge clk);
        op = o; op1 = a; op2 = bb; tag = t; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    // Edges after the accepting edge until o_valid is seen; 300 means it never came.
    task automatic wait_result(output int cyc);
        cyc = 0;
        while (obs_valid !== 1'b1 && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic consume();
        @(negedge clk); rr = 1'b1;
        @(posedge clk); #1; rr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs_valid !== 1'b0 || obs_ready !== 1'b1 || obs_busy !== 1'b0 ||
            obs_result !== 64'h0 || obs_tag !== 4'h0) begin
            errors++;
            $display("FAIL reset sel=%0d got v=%b r=%b b=%b res=%h tag=%h want 0 1 0 0 0",
                     sel, obs_valid, obs_ready, obs_busy, obs_result, obs_tag);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_mul();
        logic [2:0]  ops [4];
        logic [63:0] as [4], bs [4], ex [4];
        logic [63:0] m, xmin, quarter;
        int cyc;
        m = mask();
        xmin    = sel ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
        quarter = sel ? 64'h4000_0000_0000_0000 : 64'h4000_0000;
        ops[0] = 3'd0; as[0] = 64'd7; bs[0] = 64'hFFFF_FFFF_FFFF_FFFD & m; ex[0] = 64'hFFFF_FFFF_FFFF_FFEB & m;
        ops[1] = 3'd1; as[1] = xmin;  bs[1] = xmin; ex[1] = quarter;
        ops[2] = 3'd2; as[2] = m;     bs[2] = m;    ex[2] = m;
        ops[3] = 3'd3; as[3] = m;     bs[3] = m;    ex[3] = m & ~64'h1;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], (i == 0) ? 4'd5 : 4'(i + 8));
            wait_result(cyc);
            checks++;
            if (cyc !== lat_norm()) begin
                errors++;
                $display("FAIL mul%0d latency sel=%0d got %0d want %0d", i, sel, cyc, lat_norm());
            end
            checks++;
            if (obs_result !== ex[i]) begin
                errors++;
                $display("FAIL mul%0d result sel=%0d got %h want %h", i, sel, obs_result, ex[i]);
            end
            checks++;
            if (obs_tag !== ((i == 0) ? 4'd5 : 4'(i + 8))) begin
                errors++;
                $display("FAIL mul%0d tag sel=%0d got %0d", i, sel, obs_tag);
            end
            consume();
            checks++;
            if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
                errors++;
                $display("FAIL mul%0d handshake sel=%0d got v=%b r=%b want 0 1", i, sel, obs_valid, obs_ready);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [4];
        logic [63:0] as [4], bs [4], ex [4];
        logic [63:0] m;
        int cyc;
        m = mask();
        ops[0] = 3'd4; as[0] = 64'hFFFF_FFFF_FFFF_FFF9 & m; bs[0] = 64'd2; ex[0] = 64'hFFFF_FFFF_FFFF_FFFD & m;
        ops[1] = 3'd6; as[1] = 64'hFFFF_FFFF_FFFF_FFF9 & m; bs[1] = 64'd2; ex[1] = m;
        ops[2] = 3'd5; as[2] = 64'd100; bs[2] = 64'd7; ex[2] = 64'd14;
        ops[3] = 3'd7; as[3] = 64'd100; bs[3] = 64'd7; ex[3] = 64'd2;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i], 4'(i + 1));
            wait_result(cyc);
            checks++;
            if (cyc !== lat_norm()) begin
                errors++;
                $display("FAIL div%0d latency sel=%0d got %0d want %0d", i, sel, cyc, lat_norm());
            end
            checks++;
            if (obs_result !== ex[i] || obs_tag !== 4'(i + 1)) begin
                errors++;
                $display("FAIL div%0d result sel=%0d got %h tag %0d want %h tag %0d",
                         i, sel, obs_result, obs_tag, ex[i], i + 1);
            end
            consume();
        end
    endtask

    // Special cases finish straight from IDLE: o_valid is up right after the accepting edge.
    task automatic test_special();
        logic [2:0]  ops [6];
        logic [63:0] as [6], bs [6], ex [6];
        logic [63:0] m, xmin;
        int cyc;
        m = mask();
        xmin = sel ? 64'h8000_0000_0000_0000 : 64'h8000_0000;
        ops[0] = 3'd4; as[0] = 64'd5; bs[0] = 64'd0; ex[0] = m;
        ops[1] = 3'd6; as[1] = 64'd5; bs[1] = 64'd0; ex[1] = 64'd5;
        ops[2] = 3'd5; as[2] = 64'd5; bs[2] = 64'd0; ex[2] = m;
        ops[3] = 3'd7; as[3] = 64'd7; bs[3] = 64'd0; ex[3] = 64'd7;
        ops[4] = 3'd4; as[4] = xmin;  bs[4] = m;     ex[4] = xmin;
        ops[5] = 3'd6; as[5] = xmin;  bs[5] = m;     ex[5] = 64'd0;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], as[i], bs[i], 4'(15 - i));
            wait_result(cyc);
            checks++;
            if (cyc !== 0) begin
                errors++;
                $display("FAIL special%0d latency sel=%0d got %0d want 0", i, sel, cyc);
            end
            checks++;
            if (obs_result !== ex[i] || obs_tag !== 4'(15 - i)) begin
                errors++;
                $display("FAIL special%0d result sel=%0d got %h tag %0d want %h tag %0d",
                         i, sel, obs_result, obs_tag, ex[i], 15 - i);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] ex;
        int cyc;
        ex = 64'hFFFF_FFFF_FFFF_FFEB & mask();
        issue(3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD & mask(), 4'd5);
        wait_result(cyc);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (obs_valid !== 1'b1 || obs_result !== ex || obs_tag !== 4'd5 || obs_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d sel=%0d got v=%b res=%h tag=%0d r=%b want 1 %h 5 0",
                         i, sel, obs_valid, obs_result, obs_tag, obs_ready, ex);
            end
        end
        consume();
        checks++;
        if (obs_valid !== 1'b0 || obs_ready !== 1'b1 || obs_result !== ex || obs_tag !== 4'd5) begin
            errors++;
            $display("FAIL release sel=%0d got v=%b r=%b res=%h tag=%0d want 0 1 %h 5",
                     sel, obs_valid, obs_ready, obs_result, obs_tag, ex);
        end
    endtask

    task automatic test_flush();
        int cyc, seen;
        issue(3'd5, 64'd1000, 64'd3, 4'd7);
        repeat (12) @(posedge clk);
        // Flush with a competing request in the same cycle
        @(negedge clk);
        flush = 1'b1; valid = 1'b1; op = 3'd0; op1 = 64'd2; op2 = 64'd3; tag = 4'd9;
        @(posedge clk); #1;
        flush = 1'b0; valid = 1'b0;
        checks++;
        if (obs_ready !== 1'b1 || obs_busy !== 1'b0 || obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle sel=%0d got r=%b b=%b v=%b want 1 0 0", sel, obs_ready, obs_busy, obs_valid);
        end
        seen = 0;
        for (int i = 0; i < lat_norm() + 4; i++) begin
            @(posedge clk); #1;
            if (obs_valid !== 1'b0 || obs_ready !== 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL flush_quiet sel=%0d got %0d active cycles want 0", sel, seen);
        end
        issue(3'd5, 64'd9, 64'd3, 4'd3);
        wait_result(cyc);
        checks++;
        if (cyc !== lat_norm() || obs_result !== 64'd3 || obs_tag !== 4'd3) begin
            errors++;
            $display("FAIL flush_next sel=%0d got lat %0d res %h tag %0d want %0d 3 3",
                     sel, cyc, obs_result, obs_tag, lat_norm());
        end
        // Flushing a pending result drops it
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        checks++;
        if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_done sel=%0d got v=%b r=%b want 0 1", sel, obs_valid, obs_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        issue(3'd3, 64'd12345, 64'd678, 4'd11);
        repeat (5) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obs_valid !== 1'b0 || obs_ready !== 1'b1 || obs_busy !== 1'b0 ||
            obs_result !== 64'h0 || obs_tag !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid sel=%0d got v=%b r=%b b=%b res=%h tag=%h want 0 1 0 0 0",
                     sel, obs_valid, obs_ready, obs_busy, obs_result, obs_tag);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; flush = 1'b0; rr = 1'b0; sel = 1'b0;
        op = '0; tag = '0; op1 = '0; op2 = '0;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            test_reset();
            test_mul();
            test_div();
            test_special();
            test_backpressure();
            test_flush();
            test_reset_mid_run();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
